// File: rtl/vision_stream_pkg.sv
// rtl/vision_stream_pkg.sv - shared beat layout, pixel/pattern types and colour-bar palette
package vision_stream_pkg;

  localparam int RGB_MSB = 25;
  localparam int RGB_LSB = 2;
  localparam int SOP_BIT = 1;
  localparam int EOP_BIT = 0;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    PAT_BARS      = 2'd0,
    PAT_GRADIENT  = 2'd1,
    PAT_CHECKER   = 2'd2,
    PAT_FRAME_CNT = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } src_state_e;

  localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
  localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
  localparam pixel_t BAR_CYAN    = 24'h00FFFF;
  localparam pixel_t BAR_GREEN   = 24'h00FF00;
  localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
  localparam pixel_t BAR_RED     = 24'hFF0000;
  localparam pixel_t BAR_BLUE    = 24'h0000FF;
  localparam pixel_t BAR_BLACK   = 24'h000000;

  function automatic pixel_t bar_rgb(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - combinational RGB lookup for the current pixel coordinate
module stream_pattern_gen
  import vision_stream_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  pattern_e        pat,
  input  logic [XW-1:0]   x,
  input  logic [YW-1:0]   y,
  input  logic [2:0]      bar,
  input  logic [7:0]      frame_cnt,
  output pixel_t          rgb
);

  logic [7:0] x8;
  logic [7:0] y8;

  // Coordinates are zero-extended or truncated to the 8-bit channel width.
  always_comb begin
    x8  = 8'(x);
    y8  = 8'(y);
    rgb = '0;
    case (pat)
      PAT_BARS:      rgb = bar_rgb(bar);
      PAT_GRADIENT:  rgb = {x8, y8, x8 ^ y8};
      PAT_CHECKER:   rgb = (x8[3] ^ y8[3]) ? 24'hFFFFFF : 24'h000000;
      PAT_FRAME_CNT: rgb = {frame_cnt, ~frame_cnt, 8'h80};
      default:       rgb = '0;
    endcase
  end

endmodule

// File: rtl/stream_pattern_source.sv
// rtl/stream_pattern_source.sv - test-pattern frame source with sop/eop markers and ready-latency-1 handshake
module stream_pattern_source
  import vision_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 26,
  parameter int IMAGE_W    = 640,
  parameter int IMAGE_H    = 480,
  parameter int BAR_W      = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int XW = $clog2(IMAGE_W);
  localparam int YW = $clog2(IMAGE_H);
  localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [XW-1:0] X_LAST   = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMAGE_H - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  src_state_e            state_q, state_d;
  pattern_e              pat_q, pat_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [2:0]            bar_q, bar_d;
  logic [BW-1:0]         bar_px_q, bar_px_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  ready_d_q, ready_d_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_done_q, frame_done_d;

  logic   sop;
  logic   eop;
  logic   start_frame;
  pixel_t rgb;

  stream_pattern_gen #(
    .XW (XW),
    .YW (YW)
  ) u_gen (
    .pat       (pat_q),
    .x         (x_q),
    .y         (y_q),
    .bar       (bar_q),
    .frame_cnt (frame_cnt_q),
    .rgb       (rgb)
  );

  // ready_in is the value ready_d takes at the upcoming edge, so it qualifies the next beat.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    x_d          = x_q;
    y_d          = y_q;
    bar_d        = bar_q;
    bar_px_d     = bar_px_q;
    frame_cnt_d  = frame_cnt_q;
    ready_d_d    = ready_in;
    valid_d      = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    sop          = (x_q == '0) && (y_q == '0);
    eop          = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      ST_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      ST_ACTIVE: begin
        if (ready_in) begin
          valid_d                   = 1'b1;
          data_d                    = '0;
          data_d[RGB_MSB:RGB_LSB]   = rgb;
          data_d[SOP_BIT]           = sop;
          data_d[EOP_BIT]           = eop;
          if (x_q == X_LAST) begin
            x_d      = '0;
            bar_d    = '0;
            bar_px_d = '0;
            y_d      = eop ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
            if (bar_px_q == BAR_LAST) begin
              bar_px_d = '0;
              bar_d    = bar_q + 3'd1;
            end else begin
              bar_px_d = bar_px_q + 1'b1;
            end
          end
          if (eop) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        if (enable) start_frame = 1'b1;
        else        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      pat_d    = pattern_e'(pattern_sel);
      x_d      = '0;
      y_d      = '0;
      bar_d    = '0;
      bar_px_d = '0;
      state_d  = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pat_q        <= PAT_BARS;
      x_q          <= '0;
      y_q          <= '0;
      bar_q        <= '0;
      bar_px_q     <= '0;
      frame_cnt_q  <= '0;
      ready_d_q    <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_q        <= bar_d;
      bar_px_q     <= bar_px_d;
      frame_cnt_q  <= frame_cnt_d;
      ready_d_q    <= ready_d_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign valid_out  = valid_q & ready_d_q;
  assign data_out   = data_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ST_ACTIVE);

endmodule
